// File: rtl/mux_n_1_ser_pkg.sv
// Shared types and constant helpers for the N:1 word selector / serialiser.
// Optional out_last output is enabled with `define MUX_N_1_SER_LAST_EN.
package mux_n_1_ser_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_SER = 1'b1
  } mode_e;

  // Ceiling log2; clog2(0) and clog2(1) both return 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned sel_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_1.sv
// Combinational N:1 word mux over a packed vector; out-of-range sel yields 0.
module mux_n_1
  import mux_n_1_ser_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 4
) (
  input  logic [sel_width(NUM_IN)-1:0] sel,
  input  logic [NUM_IN*WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]             data_out
);

  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (32'(sel) == i) data_out = data_in[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_n_1_ser.sv
// Registered N:1 selector / serialiser with valid/ready on both sides.
// `define MUX_N_1_SER_LAST_EN adds the registered out_last port.
module mux_n_1_ser
  import mux_n_1_ser_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned IN_WIDTH = NUM_IN * WIDTH,
  parameter int unsigned SEL_W    = sel_width(NUM_IN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] data_in,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef MUX_N_1_SER_LAST_EN
  output logic                out_last,
`endif
  output logic [WIDTH-1:0]    data_out,
  output logic [SEL_W-1:0]    out_idx
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  mode_e            mode_q, mode_d, mode_eff;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [SEL_W-1:0] out_idx_q, out_idx_d;
  logic [SEL_W-1:0] mux_sel;
  logic [WIDTH-1:0] mux_word;
  logic             load;
  logic             last_word;

  // Mode is sampled only at a vector boundary; mid-vector the latched mode wins.
  always_comb begin
    mode_eff  = (cnt_q == '0) ? mode_e'(mode) : mode_q;
    mux_sel   = (mode_eff == MODE_SER) ? cnt_q : sel;
    load      = in_valid && (!out_valid_q || out_ready);
    last_word = (mode_eff == MODE_SEL) || (cnt_q == LAST_IDX);
  end

  mux_n_1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .sel      (mux_sel),
    .data_in  (data_in),
    .data_out (mux_word)
  );

  always_comb begin
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    out_idx_d   = out_idx_q;
    if (load) begin
      out_valid_d = 1'b1;
      data_out_d  = mux_word;
      out_idx_d   = mux_sel;
      mode_d      = mode_eff;
      if (mode_eff == MODE_SER) begin
        cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + SEL_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= MODE_SEL;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      out_idx_q   <= out_idx_d;
    end
  end

`ifdef MUX_N_1_SER_LAST_EN
  logic out_last_q, out_last_d;

  always_comb begin
    out_last_d = out_last_q;
    if (load) out_last_d = last_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_last_q <= 1'b0;
    else       out_last_q <= out_last_d;
  end

  assign out_last = out_last_q;
`endif

  // The vector is released upstream only together with its final word.
  always_comb begin
    in_ready  = load && last_word;
    out_valid = out_valid_q;
    data_out  = data_out_q;
    out_idx   = out_idx_q;
  end

endmodule
